// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: command opcodes, FSM state type and default operand addresses
package sys_ctrl_pkg;
    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
    localparam int OPA_ADDR_DEF = 0;
    localparam int OPB_ADDR_DEF = 1;
    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B,
        ALU_FUN, ALU_START, ALU_WAIT, TX_LO, TX_HI
    } state_t;
endpackage

// File: rtl/sys_ctrl_if.sv
// sys_ctrl_if: UART RX/TX, register-file and ALU signals seen by the command sequencer
interface sys_ctrl_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_FUN_WIDTH = 4
);
    logic [DATA_WIDTH-1:0]    rx_data;
    logic                     rx_valid;
    logic [ADDR_WIDTH-1:0]    rf_addr;
    logic                     rf_wr_en;
    logic [DATA_WIDTH-1:0]    rf_wr_data;
    logic                     rf_rd_en;
    logic [DATA_WIDTH-1:0]    rf_rd_data;
    logic                     rf_rd_valid;
    logic                     alu_en;
    logic [ALU_FUN_WIDTH-1:0] alu_fun;
    logic [2*DATA_WIDTH-1:0]  alu_out;
    logic                     alu_out_valid;
    logic                     alu_clk_en;
    logic [DATA_WIDTH-1:0]    tx_data;
    logic                     tx_valid;
    logic                     tx_ready;
    logic                     busy;
    modport master (
        input  rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_ready,
        output rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, alu_en, alu_fun, alu_clk_en,
               tx_data, tx_valid, busy
    );
    modport slave (
        output rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_ready,
        input  rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, alu_en, alu_fun, alu_clk_en,
               tx_data, tx_valid, busy
    );
endinterface

// File: rtl/sys_ctrl_tx.sv
// sys_ctrl_tx: result buffer that returns the low byte, then optionally the high byte, over valid/ready
module sys_ctrl_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    two,
    input  logic [2*DATA_WIDTH-1:0] result,
    input  logic                    tx_ready,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_valid,
    output logic                    more
);
    logic [DATA_WIDTH-1:0] hi;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            hi       <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            more     <= 1'b0;
        end else if (load) begin
            hi       <= result[2*DATA_WIDTH-1:DATA_WIDTH];
            tx_data  <= result[DATA_WIDTH-1:0];
            tx_valid <= 1'b1;
            more     <= two;
        end else if (tx_valid && tx_ready) begin
            tx_data  <= more ? hi : tx_data;
            tx_valid <= more;
            more     <= 1'b0;
        end
endmodule

// File: rtl/sys_ctrl.sv
// sys_ctrl: UART command sequencer driving register file / ALU and returning results byte-wise.
// Define SYS_CTRL_TIMEOUT_EN for the inter-byte watchdog and the err_timeout port.
module sys_ctrl import sys_ctrl_pkg::*; #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_FUN_WIDTH = 4,
    parameter int OPA_ADDR      = OPA_ADDR_DEF,
    parameter int OPB_ADDR      = OPB_ADDR_DEF
`ifdef SYS_CTRL_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input logic       clk,
    input logic       reset,
    sys_ctrl_if.master bus
`ifdef SYS_CTRL_TIMEOUT_EN
    , output logic    err_timeout
`endif
);
    state_t state, nxt;
    logic rxv, hs, more, load, wr_hit, tmo;
    logic [DATA_WIDTH-1:0] rx_byte;
    assign rxv     = bus.rx_valid;
    assign rx_byte = bus.rx_data;
    assign hs      = bus.tx_valid && bus.tx_ready;
    assign wr_hit  = rxv && state inside {WR_DATA, ALU_A, ALU_B};
    assign load    = (state == RD_WAIT && bus.rf_rd_valid) || (state == ALU_WAIT && bus.alu_out_valid);
`ifdef SYS_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt;
    logic collecting;
    assign collecting = state inside {WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN};
    assign tmo = collecting && !rxv && cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt         <= '0;
            err_timeout <= 1'b0;
        end else begin
            cnt         <= collecting && !rxv && !tmo ? cnt + 1'b1 : '0;
            err_timeout <= tmo ? 1'b1 :
                           state == IDLE && rxv && rx_byte inside {CMD_WR, CMD_RD, CMD_ALU_OP, CMD_ALU_NOP} ? 1'b0 :
                           err_timeout;
        end
`else
    assign tmo = 1'b0;
`endif
    always_comb begin
        nxt = state;
        case (state)
            IDLE:      if (rxv) nxt = rx_byte == CMD_WR      ? WR_ADDR :
                                      rx_byte == CMD_RD      ? RD_ADDR :
                                      rx_byte == CMD_ALU_OP  ? ALU_A   :
                                      rx_byte == CMD_ALU_NOP ? ALU_FUN : IDLE;
            WR_ADDR:   if (rxv) nxt = WR_DATA;
            WR_DATA:   if (rxv) nxt = IDLE;
            RD_ADDR:   if (rxv) nxt = RD_WAIT;
            RD_WAIT:   if (bus.rf_rd_valid) nxt = TX_LO;
            ALU_A:     if (rxv) nxt = ALU_B;
            ALU_B:     if (rxv) nxt = ALU_FUN;
            ALU_FUN:   if (rxv) nxt = ALU_START;
            ALU_START: nxt = ALU_WAIT;
            ALU_WAIT:  if (bus.alu_out_valid) nxt = TX_LO;
            TX_LO:     if (hs) nxt = more ? TX_HI : IDLE;
            TX_HI:     if (hs) nxt = IDLE;
            default:   nxt = IDLE;
        endcase
        if (tmo) nxt = IDLE;
    end
    // outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state          <= IDLE;
            bus.busy       <= 1'b0;
            bus.alu_clk_en <= 1'b0;
            bus.rf_wr_en   <= 1'b0;
            bus.rf_rd_en   <= 1'b0;
            bus.alu_en     <= 1'b0;
            bus.rf_addr    <= '0;
            bus.rf_wr_data <= '0;
            bus.alu_fun    <= '0;
        end else begin
            state          <= nxt;
            bus.busy       <= nxt != IDLE;
            bus.alu_clk_en <= nxt inside {ALU_FUN, ALU_START, ALU_WAIT};
            bus.rf_wr_en   <= wr_hit;
            bus.rf_rd_en   <= rxv && state == RD_ADDR;
            bus.alu_en     <= state == ALU_START;
            bus.rf_addr    <= !rxv ? bus.rf_addr :
                              state inside {WR_ADDR, RD_ADDR} ? rx_byte[ADDR_WIDTH-1:0] :
                              state == ALU_A ? ADDR_WIDTH'(OPA_ADDR) :
                              state == ALU_B ? ADDR_WIDTH'(OPB_ADDR) : bus.rf_addr;
            bus.rf_wr_data <= wr_hit ? rx_byte : bus.rf_wr_data;
            bus.alu_fun    <= rxv && state == ALU_FUN ? rx_byte[ALU_FUN_WIDTH-1:0] : bus.alu_fun;
        end
    sys_ctrl_tx #(.DATA_WIDTH(DATA_WIDTH)) u_tx (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .two      (state == ALU_WAIT),
        .result   (state == ALU_WAIT ? bus.alu_out : {{DATA_WIDTH{1'b0}}, bus.rf_rd_data}),
        .tx_ready (bus.tx_ready),
        .tx_data  (bus.tx_data),
        .tx_valid (bus.tx_valid),
        .more     (more)
    );
endmodule

// File: doc/sys_ctrl.md
Name: sys_ctrl

Overview:
- Command sequencer between the UART byte stream and the register file / ALU datapath.
- Parses frames from the UART RX path (0xAA write, 0xBB read, 0xCC ALU with operands, 0xDD ALU no operands).
- Drives register-file and ALU strobes, then returns results byte-wise to the UART TX path through a valid/ready handshake.
- Lives in the ref_clk domain, behind the RX/TX clock-domain synchronizers.

Parameters:
- DATA_WIDTH, 8, frame/register data width
- ADDR_WIDTH, 4, register-file address width; address byte truncated to low ADDR_WIDTH bits
- ALU_FUN_WIDTH, 4, ALU function-code width; function byte truncated to low bits
- OPA_ADDR, 0, register address holding ALU operand A
- OPB_ADDR, 1, register address holding ALU operand B
- TIMEOUT_CYCLES, 1024, inter-byte watchdog limit (optional feature only)

Ports:
- clk  in  1  ref_clk-domain clock
- reset  in  1  asynchronous, active-high reset
- rx_data  in  DATA_WIDTH  received byte
- rx_valid  in  1  one-cycle pulse, rx_data valid; no backpressure
- rf_addr  out  ADDR_WIDTH  register-file address
- rf_wr_en  out  1  one-cycle write strobe
- rf_wr_data  out  DATA_WIDTH  write data
- rf_rd_en  out  1  one-cycle read strobe
- rf_rd_data  in  DATA_WIDTH  read data
- rf_rd_valid  in  1  read data valid pulse
- alu_en  out  1  one-cycle ALU start
- alu_fun  out  ALU_FUN_WIDTH  ALU function code
- alu_out  in  2*DATA_WIDTH  ALU result
- alu_out_valid  in  1  result valid pulse
- alu_clk_en  out  1  ALU clock-gate enable
- tx_data  out  DATA_WIDTH  byte to transmit
- tx_valid  out  1  held high until accepted
- tx_ready  in  1  TX accepts byte when tx_valid and tx_ready both high
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, active-high): state IDLE; every output 0.
- All outputs are registered. Strobes last exactly one cycle.
- rx_valid is sampled only in byte-collecting states. Bytes arriving in any wait or TX state are dropped silently.
- States and transitions:
  - IDLE:
    - 0xAA -> WR_ADDR
    - 0xBB -> RD_ADDR
    - 0xCC -> ALU_A
    - 0xDD -> ALU_FUN
    - any other byte ignored, stay IDLE
  - WR_ADDR: latch addr -> WR_DATA.
  - WR_DATA: on byte, rf_wr_en=1 with rf_addr and rf_wr_data for one cycle -> IDLE.
  - RD_ADDR: on byte, rf_rd_en=1 for one cycle -> RD_WAIT.
  - RD_WAIT: on rf_rd_valid, capture rf_rd_data into tx buffer -> TX_LO. The single byte is sent in TX_LO; TX_HI is skipped.
  - ALU_A: on byte, write it to OPA_ADDR (rf_wr_en pulse) -> ALU_B.
  - ALU_B: on byte, write it to OPB_ADDR -> ALU_FUN.
  - ALU_FUN: on byte, latch alu_fun -> ALU_START.
  - ALU_START: alu_en=1 for one cycle -> ALU_WAIT.
  - ALU_WAIT: on alu_out_valid, capture 16-bit result -> TX_LO.
  - TX_LO: tx_valid=1, tx_data=result[7:0]. On handshake -> TX_HI (ALU command) or IDLE (read command).
  - TX_HI: tx_valid=1, tx_data=result[15:8]. On handshake -> IDLE.
- alu_clk_en is high from ALU_FUN entry through ALU_WAIT exit; low otherwise.
- Latency:
  - Write strobe appears 1 cycle after the data-byte rx_valid.
  - alu_en appears 2 cycles after the function-byte rx_valid.
  - tx_valid rises 1 cycle after rf_rd_valid or alu_out_valid.
- tx_data must stay stable while tx_valid is high and tx_ready is low.
- rf_rd_valid or alu_out_valid outside its wait state is ignored.
- Reset asserted mid-command aborts immediately. Any partial frame is discarded; the next byte after release is parsed as a command.

Optional Feature:
- Macro: SYS_CTRL_TIMEOUT_EN.
- Defined: a counter runs in WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B and ALU_FUN, cleared on each accepted byte. On reaching TIMEOUT_CYCLES it forces IDLE, pulses sticky output err_timeout (port exists only when defined) until the next command byte.
- Undefined: no counter, no port; the controller waits indefinitely for the next byte.

Decomposition:
- Package sys_ctrl_pkg:
  - command opcodes CMD_WR=8'hAA, CMD_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD
  - state enum typedef
  - OPA/OPB default addresses
- One natural sub-module: sys_ctrl_tx, which holds the result buffer and sequences LO/HI bytes over valid/ready.

Test Plan:
- Write: rx AA,05,77 -> one-cycle rf_wr_en with rf_addr=5, rf_wr_data=0x77; busy low afterward.
- Read: rx BB,05; model returns 0x77 one cycle after rf_rd_en -> single TX byte 0x77, no second byte.
- ALU with operands: rx CC,05,03,01 (fun 1); ALU model returns 0x0002 -> writes addr0=05 and addr1=03, alu_en pulse with alu_fun=1, TX bytes 0x02 then 0x00.
- ALU without operands: rx DD,00 after the previous test; model returns 0x0008 -> no rf writes, TX 0x08 then 0x00.
- Robustness: rx 0x12 in IDLE -> ignored. Hold tx_ready low for 20 cycles -> tx_data stable, tx_valid held. Extra rx byte during ALU_WAIT -> dropped.
- Reset after rx AA,05 -> all outputs 0; next rx 77 is ignored as an unknown opcode, no write.
